branch_predictor: RTL

Gshare direction predictor feeding the fetch-stage next-PC selector. Each cycle it reads a pattern history table (PHT) of 2-bit saturating counters for the current fetch PC and produces `F_train_predict_o`, which gates the branch-target choice for the next PC. It keeps a speculative global history register (GHR) and trains counters from branches resolved in execute. On a mispredict it restores the GHR from the snapshot carried down the pipe.

---
 rtl/branch_predictor_pkg.sv | 14 +
 rtl/bp_sat_ctr.sv | 20 ++
 rtl/branch_predictor.sv | 93 +++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the gshare direction predictor.
package branch_predictor_pkg;

  // 2-bit saturating direction counter states.
  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_e;

  localparam bp_ctr_e BP_RESET_CTR = BP_WNT;

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational next-state for a 2-bit saturating direction counter.
module bp_sat_ctr
  import branch_predictor_pkg::*;
(
  input  bp_ctr_e ctr_i,
  input  logic    taken_i,
  output bp_ctr_e ctr_o
);

  // Step toward taken/not-taken, holding at the extremes.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != BP_ST) ctr_o = bp_ctr_e'(2'(ctr_i + 2'd1));
    end else begin
      if (ctr_i != BP_SNT) ctr_o = bp_ctr_e'(2'(ctr_i - 2'd1));
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor: flop-based PHT, speculative GHR with
// mispredict recovery from the pipelined snapshot, and perf counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int IDX_WIDTH  = 6,
  parameter int HIST_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   F_PC_i,
  input  logic                  F_valid_i,
  input  logic                  mini_op_branch_i,
  output logic                  F_train_predict_o,
  output logic [HIST_WIDTH-1:0] F_ghr_o,
  input  logic                  E_update_i,
  input  logic [PC_WIDTH-1:0]   E_PC_i,
  input  logic [HIST_WIDTH-1:0] E_ghr_i,
  input  logic                  E_taken_i,
  input  logic                  E_mispredict_i,
  output logic [31:0]           perf_branch_o,
  output logic [31:0]           perf_mispred_o
);

  localparam int unsigned PHT_ENTRIES = 1 << IDX_WIDTH;

  bp_ctr_e               pht_q [PHT_ENTRIES];
  logic [HIST_WIDTH-1:0] ghr_q, ghr_d;
  logic [31:0]           perf_branch_q, perf_branch_d;
  logic [31:0]           perf_mispred_q, perf_mispred_d;

  logic [IDX_WIDTH-1:0]  f_idx, e_idx;
  logic [1:0]            f_ctr;
  bp_ctr_e               e_ctr_next;
  logic                  e_recover;

  assign f_idx = F_PC_i[IDX_WIDTH+1:2] ^ IDX_WIDTH'(ghr_q);
  assign e_idx = E_PC_i[IDX_WIDTH+1:2] ^ IDX_WIDTH'(E_ghr_i);
  assign f_ctr = pht_q[f_idx];

  assign F_train_predict_o = f_ctr[1];
  assign F_ghr_o           = ghr_q;
  assign perf_branch_o     = perf_branch_q;
  assign perf_mispred_o    = perf_mispred_q;
  assign e_recover         = E_update_i & E_mispredict_i;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{F_PC_i[PC_WIDTH-1:IDX_WIDTH+2], F_PC_i[1:0],
                            E_PC_i[PC_WIDTH-1:IDX_WIDTH+2], E_PC_i[1:0]};

  bp_sat_ctr u_sat_ctr (
    .ctr_i   (pht_q[e_idx]),
    .taken_i (E_taken_i),
    .ctr_o   (e_ctr_next)
  );

  // Next GHR and perf counts; recovery wins and discards the wrong-path fetch shift.
  always_comb begin
    ghr_d          = ghr_q;
    perf_branch_d  = perf_branch_q;
    perf_mispred_d = perf_mispred_q;
    if (e_recover)
      ghr_d = {E_ghr_i[HIST_WIDTH-2:0], E_taken_i};
    else if (F_valid_i && mini_op_branch_i)
      ghr_d = {ghr_q[HIST_WIDTH-2:0], F_train_predict_o};
    if (E_update_i) perf_branch_d = perf_branch_q + 32'd1;
    if (e_recover)  perf_mispred_d = perf_mispred_q + 32'd1;
  end

  // History and perf registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q          <= '0;
      perf_branch_q  <= '0;
      perf_mispred_q <= '0;
    end else begin
      ghr_q          <= ghr_d;
      perf_branch_q  <= perf_branch_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  // PHT: whole-table reset in one cycle, single training write per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= BP_RESET_CTR;
    end else if (E_update_i) begin
      pht_q[e_idx] <= e_ctr_next;
    end
  end

endmodule
